// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 transmit framer: header constant and FSM states.
package rc4_pkg;
  localparam logic [7:0] FRAME_HDR = 8'hA5;

  typedef enum logic [2:0] {IDLE, HDR, LEN, PAY, CSUM} tx_state_t;
endpackage

// File: rtl/rc4_tx_framer_frame_buf.sv
// Circular byte buffer: write/pop strobes, head byte plus the byte behind it, and fill level.
module frame_buf #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [7:0]               head_nxt,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_inc;

  assign rd_ptr_inc = rd_ptr + 1'b1;
  assign head       = mem[rd_ptr];
  // Byte presented after a pop; only consumed when at least two bytes are buffered.
  assign head_nxt   = mem[rd_ptr_inc];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr_inc;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/rc4_tx_framer.sv
// Packs captured RC4 bytes into A5 / N / payload / XOR-checksum frames on a valid/ready stream.
module rc4_tx_framer
  import rc4_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             enc_data,
  input  logic                   enc_done,
  input  logic                   flush,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);
  localparam int LW = $clog2(DEPTH) + 1;

  tx_state_t  state, state_d;
  logic [7:0] head, head_nxt;
  logic [7:0] n_len, n_d, rem, rem_d, csum, csum_d, data_d, len_sel;
  logic       valid_d, sof_d, eof_d;
  logic       pop, wr_en, xfer, start, flush_drop, flush_pend, full_frame;

  assign wr_en      = enc_done && (level < LW'(DEPTH));
  assign xfer       = out_valid && out_ready;
  assign full_frame = 32'(level) >= FRAME_LEN;
  assign len_sel    = full_frame ? 8'(FRAME_LEN) : 8'(level);

  frame_buf #(.DEPTH(DEPTH)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (enc_data),
    .pop      (pop),
    .head     (head),
    .head_nxt (head_nxt),
    .level    (level)
  );

  // Outputs are registered from the next state, so the byte for each state is ready on entry.
  always_comb begin
    state_d    = state;
    valid_d    = out_valid;
    data_d     = out_data;
    sof_d      = out_sof;
    eof_d      = out_eof;
    n_d        = n_len;
    rem_d      = rem;
    csum_d     = csum;
    pop        = 1'b0;
    start      = 1'b0;
    flush_drop = 1'b0;
    case (state)
      IDLE: begin
        if (full_frame || (flush_pend && level != '0)) begin
          state_d = HDR;
          valid_d = 1'b1;
          data_d  = FRAME_HDR;
          sof_d   = 1'b1;
          eof_d   = 1'b0;
          n_d     = len_sel;
          rem_d   = len_sel;
          csum_d  = '0;
          start   = 1'b1;
        end else if (flush_pend) begin
          flush_drop = 1'b1;
        end
      end
      HDR: if (xfer) begin
        state_d = LEN;
        data_d  = n_len;
        sof_d   = 1'b0;
      end
      LEN: if (xfer) begin
        state_d = PAY;
        data_d  = head;
      end
      PAY: if (xfer) begin
        pop    = 1'b1;
        csum_d = csum ^ head;
        rem_d  = rem - 8'd1;
        if (rem == 8'd1) begin
          state_d = CSUM;
          data_d  = csum ^ head;
          eof_d   = 1'b1;
        end else begin
          data_d  = head_nxt;
        end
      end
      CSUM: if (xfer) begin
        state_d = IDLE;
        valid_d = 1'b0;
        data_d  = '0;
        eof_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      rem        <= '0;
      flush_pend <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_d;
      out_valid  <= valid_d;
      out_data   <= data_d;
      out_sof    <= sof_d;
      out_eof    <= eof_d;
      rem        <= rem_d;
      flush_pend <= flush | (flush_pend & ~(start | flush_drop));
      overflow   <= overflow | (enc_done & ~wr_en);
    end
  end

  always_ff @(posedge clk) begin
    n_len <= n_d;
    csum  <= csum_d;
  end
endmodule
